// File: rtl/updown_limit_counter.sv
// Up/down counter with programmable step, runtime [limit_lo, limit_hi] window,
// wrap or saturate at the boundary, enable prescaler, parallel load and tc/sticky flag.
module updown_limit_counter #(
  parameter int                WIDTH    = 32,
  parameter int unsigned       STEP     = 1,
  parameter logic [WIDTH-1:0]  SEED     = '0,
  parameter int                PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit_lo,
  input  logic [WIDTH-1:0] limit_hi,
  input  logic             clr_flag,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             bnd_flag,
  output logic             cfg_err
);

  localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PS_LAST  = PW'(PRESCALE - 1);
  localparam logic [WIDTH:0] STEP_X   = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0] STEP_N = STEP_X[WIDTH-1:0];

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    psc_q, psc_d;
  logic             tc_q, tc_d;
  logic             flag_q, flag_d;

  logic             tick;
  logic [WIDTH:0]   sum_up;
  logic [WIDTH:0]   lo_step;
  logic             hit_up;
  logic             hit_dn;

  assign cfg_err = limit_lo > limit_hi;
  assign tick    = en & ~cfg_err & (psc_q == PS_LAST);

  // One extra bit on both sides so neither the up-sum nor lo+STEP can wrap.
  assign sum_up  = {1'b0, count_q} + STEP_X;
  assign lo_step = {1'b0, limit_lo} + STEP_X;
  assign hit_up  = sum_up > {1'b0, limit_hi};
  assign hit_dn  = {1'b0, count_q} < lo_step;

  always_comb begin
    count_d = count_q;
    psc_d   = psc_q;
    tc_d    = 1'b0;
    flag_d  = flag_q & ~clr_flag;
    if (load) begin
      count_d = load_val;
      psc_d   = '0;
    end else if (en && !cfg_err) begin
      psc_d = tick ? '0 : psc_q + PW'(1);
      if (tick) begin
        if (up ? hit_up : hit_dn) begin
          tc_d   = 1'b1;
          flag_d = 1'b1;
          if (sat_mode) count_d = up ? limit_hi : limit_lo;
          else          count_d = up ? limit_lo : limit_hi;
        end else begin
          count_d = up ? sum_up[WIDTH-1:0] : count_q - STEP_N;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= SEED;
      psc_q   <= '0;
      tc_q    <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      psc_q   <= psc_d;
      tc_q    <= tc_d;
      flag_q  <= flag_d;
    end
  end

  assign count    = count_q;
  assign tc       = tc_q;
  assign bnd_flag = flag_q;

endmodule
